// File: rtl/trace_issue_buffer_pkg.sv
// Shared trace-entry types and widths used by the parser, issue buffer and request queue.
package trace_issue_buffer_pkg;

  localparam int unsigned AddrWidth = 33;
  localparam int unsigned TimeWidth = 32;

  typedef enum logic [1:0] {
    OpRead    = 2'd0,
    OpWrite   = 2'd1,
    OpIfetch  = 2'd2,
    OpIllegal = 2'd3
  } trace_op_t;

  typedef struct packed {
    logic [TimeWidth-1:0] cpu_time;
    trace_op_t            opcode;
    logic [AddrWidth-1:0] address;
  } trace_entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StHold,
    StIssue,
    StDone
  } tib_state_t;

endpackage

// File: rtl/trace_entry_fifo.sv
// Depth-entry circular FIFO of trace entries with registered pointers and occupancy count.
module trace_entry_fifo
  import trace_issue_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  trace_entry_t             entry_i,
  input  logic                     pop_i,
  output trace_entry_t             head_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  trace_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; pointers wrap naturally since Depth is a power of two.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/trace_issue_buffer.sv
// Buffers decoded trace entries and releases each once simulation time reaches its CPU time.
module trace_issue_buffer
  import trace_issue_buffer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = AddrWidth,
  parameter int unsigned TIME_WIDTH    = TimeWidth,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STALL_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TIME_WIDTH-1:0]     in_time,
  input  logic [1:0]                in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]  in_address,
  input  logic                      in_last,
  input  logic [TIME_WIDTH-1:0]     sim_time,
  input  logic                      queue_empty,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [TIME_WIDTH-1:0]     out_time,
  output logic [1:0]                out_opcode,
  output logic [ADDRESS_WIDTH-1:0]  out_address,
  input  logic                      skip_en,
  output logic                      time_skip_valid,
  output logic [TIME_WIDTH-1:0]     time_skip_value,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      done,
  output logic                      err_order,
  output logic                      err_opcode,
  output logic [STALL_WIDTH-1:0]    stall_cycles
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  trace_entry_t           in_entry, head;
  logic                   fifo_full, fifo_empty;
  logic [CntW-1:0]        fifo_count;
  logic                   accept, illegal, push, pop, head_due, empty_next;
  logic [TIME_WIDTH-1:0]  head_time;

  logic                   last_seen_q, last_seen_d;
  logic                   err_order_q, err_order_d;
  logic                   err_opcode_q, err_opcode_d;
  logic [TIME_WIDTH-1:0]  prev_time_q, prev_time_d;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;
  tib_state_t             state_q, state_d;

  trace_entry_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (in_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake, due check and skip hint; in_ready depends on registered state only.
  always_comb begin
    in_ready          = !fifo_full && !last_seen_q;
    accept            = in_valid && in_ready;
    illegal           = (in_opcode == OpIllegal);
    // Illegal beats complete the handshake but are dropped here.
    push              = accept && !illegal;
    in_entry.cpu_time = TimeWidth'(in_time);
    in_entry.opcode   = trace_op_t'(in_opcode);
    in_entry.address  = AddrWidth'(in_address);
    head_time         = TIME_WIDTH'(head.cpu_time);
    head_due          = !fifo_empty && (head_time <= sim_time);
    out_valid         = head_due;
    pop               = head_due && out_ready;
    out_time          = head_time;
    out_opcode        = head.opcode;
    out_address       = ADDRESS_WIDTH'(head.address);
    time_skip_valid   = skip_en && !fifo_empty && queue_empty && (head_time > sim_time);
    time_skip_value   = head_time;
    count             = fifo_count;
    done              = (state_q == StDone);
    err_order         = err_order_q;
    err_opcode        = err_opcode_q;
    stall_cycles      = stall_q;
  end

  // Sticky flags, last-line tracking, order reference time and saturating stall counter.
  always_comb begin
    last_seen_d  = last_seen_q || (accept && in_last);
    err_order_d  = err_order_q || (accept && (in_time < prev_time_q));
    err_opcode_d = err_opcode_q || (accept && illegal);
    prev_time_d  = accept ? in_time : prev_time_q;
    stall_d      = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_WIDTH'(1);
    end
  end

  // Next-state; Hold/Issue is a registered snapshot, the live issue decision is out_valid.
  always_comb begin
    empty_next = ((fifo_count == '0) && !push) ||
                 ((fifo_count == CntW'(1)) && pop && !push);
    state_d    = state_q;
    if (state_q != StDone) begin
      if (empty_next) begin
        state_d = last_seen_d ? StDone : StEmpty;
      end else if (head_due && !pop) begin
        state_d = StIssue;
      end else begin
        state_d = StHold;
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_seen_q  <= 1'b0;
      err_order_q  <= 1'b0;
      err_opcode_q <= 1'b0;
      prev_time_q  <= '0;
      stall_q      <= '0;
      state_q      <= StEmpty;
    end else begin
      last_seen_q  <= last_seen_d;
      err_order_q  <= err_order_d;
      err_opcode_q <= err_opcode_d;
      prev_time_q  <= prev_time_d;
      stall_q      <= stall_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_trace_issue_buffer.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a queue model.
module tb_trace_issue_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_time;
  logic [1:0]  in_opcode;
  logic [32:0] in_address;
  logic        in_last;
  logic [31:0] sim_time;
  logic        queue_empty, out_ready, out_valid;
  logic [31:0] out_time;
  logic [1:0]  out_opcode;
  logic [32:0] out_address;
  logic        skip_en, time_skip_valid;
  logic [31:0] time_skip_value;
  logic [2:0]  count;
  logic        done, err_order, err_opcode;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  trace_issue_buffer #(
    .ADDRESS_WIDTH (33),
    .TIME_WIDTH    (32),
    .DEPTH         (DEPTH),
    .STALL_WIDTH   (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_time         (in_time),
    .in_opcode       (in_opcode),
    .in_address      (in_address),
    .in_last         (in_last),
    .sim_time        (sim_time),
    .queue_empty     (queue_empty),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_time        (out_time),
    .out_opcode      (out_opcode),
    .out_address     (out_address),
    .skip_en         (skip_en),
    .time_skip_valid (time_skip_valid),
    .time_skip_value (time_skip_value),
    .count           (count),
    .done            (done),
    .err_order       (err_order),
    .err_opcode      (err_opcode),
    .stall_cycles    (stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: an ordered list of held entries plus a few flags.
  typedef struct {
    logic [31:0] t;
    logic [1:0]  op;
    logic [32:0] a;
  } ent_t;

  ent_t        mq[$];
  bit          m_last, m_done, m_eord, m_eop, model_ok;
  logic [31:0] m_stall, m_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input bit e_ir, input bit e_ov);
    bit e_tsv;
    e_tsv = skip_en && (mq.size() != 0) && queue_empty && (mq[0].t > sim_time);
    chk("in_ready", 64'(in_ready), 64'(e_ir));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov) begin
      chk("out_time", 64'(out_time), 64'(mq[0].t));
      chk("out_opcode", 64'(out_opcode), 64'(mq[0].op));
      chk("out_address", 64'(out_address), 64'(mq[0].a));
    end
    chk("time_skip_valid", 64'(time_skip_valid), 64'(e_tsv));
    if (e_tsv) chk("time_skip_value", 64'(time_skip_value), 64'(mq[0].t));
    chk("count", 64'(count), 64'(mq.size()));
    chk("done", 64'(done), 64'(m_done));
    chk("err_order", 64'(err_order), 64'(m_eord));
    chk("err_opcode", 64'(err_opcode), 64'(m_eop));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
  endtask

  task automatic model_update(input bit e_ir, input bit e_ov);
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_last = 0; m_done = 0; m_eord = 0; m_eop = 0;
      m_stall = 0; m_prev = 0; model_ok = 1;
      return;
    end
    if (!model_ok) return;
    if (e_ov) begin
      if (out_ready) void'(mq.pop_front());
      else if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    if (in_valid && e_ir) begin
      if (in_time < m_prev) m_eord = 1;
      m_prev = in_time;
      if (in_opcode == 2'd3) m_eop = 1;
      else begin
        e.t = in_time; e.op = in_opcode; e.a = in_address;
        mq.push_back(e);
      end
      if (in_last) m_last = 1;
    end
    if (m_last && mq.size() == 0) m_done = 1;
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic tick();
    bit e_ir, e_ov;
    #1;
    e_ir = (mq.size() < DEPTH) && !m_last;
    e_ov = (mq.size() != 0) && (mq[0].t <= sim_time);
    if (model_ok) model_check(e_ir, e_ov);
    @(posedge clk);
    model_update(e_ir, e_ov);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] t, input logic [1:0] op,
                       input logic [32:0] a, input bit last);
    in_valid = v; in_time = t; in_opcode = op; in_address = a; in_last = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] t;
    logic [1:0]  op;
    logic [32:0] a;
    bit          last;
    logic [31:0] sim;
    bit          qe, ordy, skip;
    bit          e_ir, e_ov;
    int          e_cnt;
    bit          e_tsv;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; model_ok = 0;
    drive(0, 0, 0, 0, 0);
    sim_time = 0; queue_empty = 0; out_ready = 0; skip_en = 0;

    // Due-time gating, single pop, and skip hint gating on queue_empty.
    tbl[0]  = '{1, 10,  0, 33'h1_0000_0040, 0,   5, 0, 1, 0, 1, 0, 0, 0};
    tbl[1]  = '{0,  0,  0, 33'h0,           0,   9, 0, 1, 0, 1, 0, 1, 0};
    tbl[2]  = '{0,  0,  0, 33'h0,           0,   9, 1, 1, 1, 1, 0, 1, 1};
    tbl[3]  = '{0,  0,  0, 33'h0,           0,  10, 1, 1, 1, 1, 1, 1, 0};
    tbl[4]  = '{0,  0,  0, 33'h0,           0,  10, 0, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 500, 1, 33'h0_0000_1234, 0, 100, 0, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0,  0,  0, 33'h0,           0, 100, 1, 1, 1, 1, 0, 1, 1};
    tbl[7]  = '{0,  0,  0, 33'h0,           0, 100, 0, 1, 1, 1, 0, 1, 0};
    tbl[8]  = '{0,  0,  0, 33'h0,           0, 500, 0, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{0,  0,  0, 33'h0,           0, 500, 0, 1, 0, 1, 1, 1, 0};
    tbl[10] = '{0,  0,  0, 33'h0,           0, 500, 0, 1, 0, 1, 0, 0, 0};

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].t, tbl[i].op, tbl[i].a, tbl[i].last);
      sim_time = tbl[i].sim; queue_empty = tbl[i].qe;
      out_ready = tbl[i].ordy; skip_en = tbl[i].skip;
      #1;
      chk($sformatf("tbl[%0d].in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl[%0d].out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl[%0d].count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl[%0d].skip_valid", i), 64'(time_skip_valid), 64'(tbl[i].e_tsv));
      tick();
    end
    skip_en = 0; queue_empty = 0;

    // Fill to DEPTH under backpressure, stall, then drain with pointer wrap.
    do_reset();
    sim_time = 0; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 33'(i), 0);
      tick();
    end
    chk("fill.count", 64'(count), 64'd4);
    chk("fill.in_ready", 64'(in_ready), 64'd0);
    drive(1, 0, 2, 33'h4, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("fill.stall", 64'(stall_cycles), 64'd6);
    out_ready = 1;
    tick();
    chk("drain.count0", 64'(count), 64'd3);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("drain.count1", 64'(count), 64'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("drain.empty", 64'(count), 64'd0);

    // Out-of-order time and illegal opcode.
    do_reset();
    out_ready = 0; sim_time = 0;
    drive(1, 20, 1, 33'h20, 0); tick();
    drive(1, 15, 2, 33'h15, 0); tick();
    drive(1, 30, 3, 33'h30, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    chk("order.err_order", 64'(err_order), 64'd1);
    chk("order.err_opcode", 64'(err_opcode), 64'd1);
    chk("order.count", 64'(count), 64'd2);
    sim_time = 100; out_ready = 1;
    #1;
    chk("order.first", 64'(out_time), 64'd20);
    tick();
    chk("order.second", 64'(out_time), 64'd15);
    tick();
    chk("order.drained", 64'(count), 64'd0);
    chk("order.sticky", 64'(err_order), 64'd1);

    // Last entry, done, reset; then an illegal last beat on an empty buffer.
    do_reset();
    sim_time = 5; out_ready = 1;
    drive(1, 1, 0, 33'h1_2345_6789, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("last.done_early", 64'(done), 64'd0);
    chk("last.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("last.done", 64'(done), 64'd1);
    chk("last.count", 64'(count), 64'd0);
    tick(); tick();
    chk("last.absorbing", 64'(done), 64'd1);
    rst_n = 0; tick(); rst_n = 1;
    chk("last.rst_done", 64'(done), 64'd0);
    chk("last.rst_count", 64'(count), 64'd0);
    chk("last.rst_in_ready", 64'(in_ready), 64'd1);
    drive(1, 7, 3, 33'h0, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("illast.done", 64'(done), 64'd1);
    chk("illast.count", 64'(count), 64'd0);
    tick();

    // Steady simultaneous push/pop at count 2 across several wraps.
    do_reset();
    sim_time = 1000; out_ready = 0;
    drive(1, 0, 0, 33'h100, 0); tick();
    drive(1, 1, 1, 33'h101, 0); tick();
    chk("stream.prefill", 64'(count), 64'd2);
    out_ready = 1;
    for (int k = 2; k < 2 + 3 * DEPTH; k++) begin
      drive(1, 32'(k), 2'(k % 3), 33'h100 + 33'(k), 0);
      tick();
      chk("stream.count", 64'(count), 64'd2);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("stream.drained", 64'(count), 64'd0);

    // Random traffic with occasional resets, out-of-order times and illegal opcodes.
    do_reset();
    sim_time = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      in_valid = $urandom_range(0, 1);
      in_time = ($urandom_range(0, 9) == 0) ? sim_time - 32'($urandom_range(0, 5))
                                            : sim_time + 32'($urandom_range(0, 30));
      in_opcode = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in_address = {1'($urandom), 32'($urandom)};
      in_last = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      queue_empty = $urandom_range(0, 1);
      skip_en = $urandom_range(0, 1);
      sim_time = sim_time + 32'($urandom_range(0, 4));
      tick();
    end
    rst_n = 1;
    drive(0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_issue_buffer.md
Name: trace_issue_buffer

Overview:
- Parametrised successor to the single-entry trace front end.
- Buffers up to DEPTH decoded trace entries (time, opcode, address) arriving on a valid/ready stream. Releases each entry to the memory-controller request queue only once simulation time reaches the entry's CPU time, honouring queue backpressure.
- Adds time-skip hinting for idle periods, end-of-trace tracking, ordering/opcode error flags and a stall counter.
- Sits between the trace-file reader and the request queue.

Parameters:
ADDRESS_WIDTH, 33, request address width
TIME_WIDTH, 32, CPU-time / simulation-time width (unsigned)
DEPTH, 4, entry buffer depth; power of two, >= 2
STALL_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  trace entry offered
in_ready  out  1  buffer accepts entry
in_time  in  TIME_WIDTH  entry CPU time
in_opcode  in  2  0=READ, 1=WRITE, 2=IFETCH, 3=illegal
in_address  in  ADDRESS_WIDTH  entry address
in_last  in  1  entry is final trace line
sim_time  in  TIME_WIDTH  current simulation time from controller
queue_empty  in  1  request queue empty
out_ready  in  1  request queue can accept (= !queue_full)
out_valid  out  1  head entry due and presented
out_time  out  TIME_WIDTH  head entry time
out_opcode  out  2  head entry opcode
out_address  out  ADDRESS_WIDTH  head entry address
skip_en  in  1  enable time-skip hint
time_skip_valid  out  1  controller may jump sim_time forward
time_skip_value  out  TIME_WIDTH  target time for jump
count  out  $clog2(DEPTH)+1  entries held
done  out  1  last entry issued, buffer empty
err_order  out  1  sticky: in_time decreased
err_opcode  out  1  sticky: illegal opcode seen
stall_cycles  out  STALL_WIDTH  cycles out_valid && !out_ready

Behaviour:
- Reset (rst_n=0 at posedge): count=0, read/write pointers=0, last_seen=0, done=0, err_order=0, err_opcode=0, stall_cycles=0, prev_time=0.
  - Outputs after reset: out_valid=0, time_skip_valid=0.
  - Reset mid-operation discards all held entries.
- Storage: circular buffer with wrapping pointers of width $clog2(DEPTH). Entries and pointers are registered; out_* are driven from the head slot.
- Push:
  - in_ready = (count < DEPTH) && !last_seen; registered-state-only, with no combinational path from out_ready.
  - Push occurs when in_valid && in_ready. The entry is visible at the head no earlier than the next cycle (1-cycle latency).
- Illegal opcode (3): the handshake completes but the entry is not stored. err_opcode is set. in_last on that beat still sets last_seen.
- Order check: a push with in_time < prev_time sets err_order; the entry is still stored. prev_time updates on every accepted beat.
- Issue:
  - out_valid = (count != 0) && (head time <= sim_time), unsigned compare.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A full buffer does not accept a push in the same cycle as a pop.
- FSM (derived, exposed only via outputs):
  - EMPTY: count=0.
  - HOLD: head not due.
  - ISSUE: head due.
  - DONE: last_seen, count=0, and the last stored entry popped.
  - Transitions follow push/pop/sim_time.
  - DONE is absorbing until reset. done=1 in DONE. An in_last beat carrying an illegal opcode with an empty buffer enters DONE the next cycle.
- Time skip:
  - time_skip_valid = skip_en && (count != 0) && queue_empty && (head time > sim_time); time_skip_value = head time. Both are combinational.
  - Inactive in DONE/EMPTY.
- Stall: stall_cycles increments each cycle with out_valid && !out_ready and saturates at all-ones.
- Equal times: multiple entries with the same time issue on consecutive cycles when out_ready=1.

Decomposition:
- global_defs package gets:
  - trace_op_t enum (READ, WRITE, IFETCH, ILLEGAL);
  - trace_entry_t struct {time, opcode, address};
  - ADDRESS_WIDTH and TIME_WIDTH constants shared with the parser and queue.
- One sub-module, trace_entry_fifo: generic DEPTH-entry circular FIFO of trace_entry_t with push/pop, count and full/empty.
- The top holds the due-check, order/opcode checks, last/done tracking, skip logic and stall counter.

Test Plan:
- Push {t=10,READ,0x1_0000_0040} with sim_time=5 -> out_valid=0 through sim_time=9; out_valid=1 at sim_time=10; pop with out_ready=1 -> count 1->0.
- Push 5 entries at t=0 with DEPTH=4, out_ready=0 -> in_ready=0 after 4 accepts; count=4; stall_cycles increments each cycle; out_ready=1 -> 4 pops on 4 consecutive cycles, pointers wrap, then the 5th entry is accepted.
- skip_en=1, queue_empty=1, head t=500, sim_time=100 -> time_skip_valid=1, time_skip_value=500; set queue_empty=0 -> time_skip_valid=0.
- Push t=20 then t=15 -> err_order=1 sticky; both issue in FIFO order. Push opcode 3 -> err_opcode=1, count unchanged.
- Push last entry with in_last=1, pop it -> done=1 the cycle after the pop; in_ready=0 afterwards; assert rst_n=0 -> done=0, count=0, in_ready=1.
- Simultaneous push and pop with count=2 -> count stays 2; data order preserved across pointer wrap over 3*DEPTH entries.
